// File: rtl/hybrid_addsub_8bit.sv
// 8-bit registered adder/subtractor: two flat 4-bit carry-lookahead slices
// chained ripple-style, with b conditionally inverted and m used as carry-in.
module hybrid_addsub_8bit (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       m,
  output logic [7:0] s,
  output logic       c7,
  output logic       cout,
  output logic       overflow
);

  logic [7:0] w_i;
  logic [7:0] w_g;
  logic [7:0] w_p;
  logic [8:0] w_c;
  logic [7:0] w_sum;
  logic [7:0] r_s;
  logic       r_c7;
  logic       r_cout;
  logic       r_ovf;

  assign w_i    = b ^ {8{m}};
  assign w_g    = a & w_i;
  assign w_p    = a ^ w_i;
  assign w_c[0] = m;

  // Each slice derives all four carries directly from its own carry-in;
  // only the slice boundary (w_c[4]) ripples.
  for (genvar j = 0; j < 2; j++) begin : g_slice
    localparam int B = 4 * j;
    assign w_c[B+1] = w_g[B]
                    | (w_p[B] & w_c[B]);
    assign w_c[B+2] = w_g[B+1]
                    | (w_p[B+1] & w_g[B])
                    | (w_p[B+1] & w_p[B] & w_c[B]);
    assign w_c[B+3] = w_g[B+2]
                    | (w_p[B+2] & w_g[B+1])
                    | (w_p[B+2] & w_p[B+1] & w_g[B])
                    | (w_p[B+2] & w_p[B+1] & w_p[B] & w_c[B]);
    assign w_c[B+4] = w_g[B+3]
                    | (w_p[B+3] & w_g[B+2])
                    | (w_p[B+3] & w_p[B+2] & w_g[B+1])
                    | (w_p[B+3] & w_p[B+2] & w_p[B+1] & w_g[B])
                    | (w_p[B+3] & w_p[B+2] & w_p[B+1] & w_p[B] & w_c[B]);
  end

  assign w_sum = w_p ^ w_c[7:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s    <= '0;
      r_c7   <= 1'b0;
      r_cout <= 1'b0;
      r_ovf  <= 1'b0;
    end else begin
      r_s    <= w_sum;
      r_c7   <= w_c[7];
      r_cout <= w_c[8];
      r_ovf  <= w_c[7] ^ w_c[8];
    end
  end

  assign s        = r_s;
  assign c7       = r_c7;
  assign cout     = r_cout;
  assign overflow = r_ovf;

endmodule

// File: tb/tb_hybrid_addsub_8bit.sv
// Directed and random checks of hybrid_addsub_8bit against an arithmetic model.
module tb_hybrid_addsub_8bit;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] a;
  logic [7:0] b;
  logic       m;
  logic [7:0] s;
  logic       c7;
  logic       cout;
  logic       overflow;

  int total = 0;
  int bad   = 0;

  hybrid_addsub_8bit dut (
    .clk(clk), .rst(rst), .a(a), .b(b), .m(m),
    .s(s), .c7(c7), .cout(cout), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [7:0] es, input logic ec7,
                           input logic eco, input logic eov);
    check({tag, ".s"},        s,               es);
    check({tag, ".c7"},       {7'd0, c7},      {7'd0, ec7});
    check({tag, ".cout"},     {7'd0, cout},    {7'd0, eco});
    check({tag, ".overflow"}, {7'd0, overflow}, {7'd0, eov});
  endtask

  // Reference: integer arithmetic on unsigned and signed interpretations.
  task automatic model(input logic [7:0] xa, input logic [7:0] xb, input logic xm,
                       output logic [7:0] es, output logic ec7, output logic eco,
                       output logic eov);
    int ua, ub, sa, sb, ur, sr;
    ua = int'(xa);
    ub = int'(xb);
    sa = (ua > 127) ? ua - 256 : ua;
    sb = (ub > 127) ? ub - 256 : ub;
    ur = xm ? ua - ub : ua + ub;
    sr = xm ? sa - sb : sa + sb;
    es  = 8'(ur & 255);
    eco = xm ? (ua >= ub) : (ur > 255);
    eov = (sr > 127) || (sr < -128);
    ec7 = eco ^ eov;
  endtask

  task automatic drive(input logic [7:0] xa, input logic [7:0] xb, input logic xm);
    a = xa; b = xb; m = xm;
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [7:0] a, b;
    logic       m;
    logic [7:0] s;
    logic       c7, co, ov;
  } vec_t;

  vec_t plan[7];

  initial begin
    logic [7:0] es;
    logic ec7, eco, eov;

    plan[0] = '{8'h00, 8'h7F, 1'b0, 8'h7F, 1'b0, 1'b0, 1'b0};
    plan[1] = '{8'h00, 8'h01, 1'b1, 8'hFF, 1'b0, 1'b0, 1'b0};
    plan[2] = '{8'h00, 8'hFF, 1'b1, 8'h01, 1'b0, 1'b0, 1'b0};
    plan[3] = '{8'h55, 8'hAA, 1'b0, 8'hFF, 1'b0, 1'b0, 1'b0};
    plan[4] = '{8'h55, 8'hAA, 1'b1, 8'hAB, 1'b1, 1'b0, 1'b1};
    plan[5] = '{8'hFF, 8'hFF, 1'b1, 8'h00, 1'b1, 1'b1, 1'b0};
    plan[6] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1};

    rst = 1'b1; a = 8'h3C; b = 8'hA5; m = 1'b0;
    @(posedge clk); #1;
    check_all("reset", 8'h00, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;

    for (int unsigned k = 0; k < 7; k++) begin
      drive(plan[k].a, plan[k].b, plan[k].m);
      check_all($sformatf("plan%0d", k), plan[k].s, plan[k].c7, plan[k].co, plan[k].ov);
    end

    // a - 0 never borrows
    drive(8'h37, 8'h00, 1'b1);
    check_all("sub_zero", 8'h37, 1'b1, 1'b1, 1'b0);

    // Reset beats inputs, then first valid result one edge later
    rst = 1'b1;
    drive(8'hFF, 8'h01, 1'b0);
    check_all("rst_hold", 8'h00, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    drive(8'hFF, 8'h01, 1'b0);
    check_all("rst_release", 8'h00, 1'b1, 1'b1, 1'b0);

    // Mid-stream reset discards the in-flight result
    drive(8'h12, 8'h34, 1'b0);
    check_all("pre_midrst", 8'h46, 1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    drive(8'h7F, 8'h7F, 1'b0);
    check_all("midrst", 8'h00, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;

    // Back-to-back random operations, each result exactly one cycle later
    for (int unsigned k = 0; k < 300; k++) begin
      logic [7:0] ra, rb;
      logic rm;
      ra = 8'($urandom);
      rb = 8'($urandom);
      rm = 1'($urandom);
      drive(ra, rb, rm);
      model(ra, rb, rm, es, ec7, eco, eov);
      check_all($sformatf("rand%0d", k), es, ec7, eco, eov);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
